// File: rtl/tag_lookup_ctrl.sv
// Tag lookup controller: reads a set's per-way tags from the tag array,
// reports hit/way, and on an allocating miss writes the new tag into a
// victim way (first invalid way, else the set's round-robin pointer).
// Valid bits and replacement pointers live here; the array holds tags only.
module tag_lookup_ctrl #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int SET_W = $clog2(SETS),
  parameter int TAG_W = 16,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SET_W-1:0]            req_set,
  input  logic [TAG_W-1:0]            req_tag,
  input  logic                        req_alloc,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_hit,
  output logic [WAY_W-1:0]            rsp_way,
  output logic                        rsp_alloc,
  output logic                        rsp_evict,
  output logic [TAG_W-1:0]            rsp_evict_tag,
  output logic                        tag_read_valid,
  input  logic                        tag_read_ready,
  output logic [SET_W-1:0]            tag_read_set,
  input  logic [WAYS-1:0][TAG_W-1:0]  tag_read_rsp,
  output logic                        tag_write_valid,
  input  logic                        tag_write_ready,
  output logic [SET_W-1:0]            tag_write_set,
  output logic [WAYS-1:0]             tag_write_way_en,
  output logic [TAG_W-1:0]            tag_write_data
);

  typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, RESP} state_t;

  state_t state_reg, state_next;

  // Captured request
  logic [SET_W-1:0] set_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             alloc_req_reg;

  // Response fields, built up in CMP/WRITE
  logic             hit_reg;
  logic [WAY_W-1:0] way_reg;
  logic             alloc_done_reg;
  logic             evict_reg;
  logic [TAG_W-1:0] evict_tag_reg;

  // Per-set line state
  logic [SETS-1:0][WAYS-1:0]  valid_reg;
  logic [SETS-1:0][WAY_W-1:0] rr_reg;

  logic [WAYS-1:0]  set_valid;
  logic [WAYS-1:0]  hit_vec;
  logic             any_hit;
  logic             any_free;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_way;

  assign set_valid = valid_reg[set_reg];

  // Per-way compare of returned tag against the captured tag, masked by valid
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = set_valid[gi] && (tag_read_rsp[gi] == tag_reg);
    end
  endgenerate

  // Lowest-index priority encode of hits and of free (invalid) ways
  always_comb begin
    any_hit  = 1'b0;
    hit_way  = '0;
    any_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!set_valid[w]) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = any_free ? free_way : rr_reg[set_reg];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid)       state_next = READ;
      READ:    if (tag_read_ready)  state_next = CMP;
      CMP:     state_next = (any_hit || !alloc_req_reg) ? RESP : WRITE;
      WRITE:   if (tag_write_ready) state_next = RESP;
      RESP:    if (rsp_ready)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, compare/victim results, valid bits and rr pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_reg        <= '0;
      tag_reg        <= '0;
      alloc_req_reg  <= 1'b0;
      hit_reg        <= 1'b0;
      way_reg        <= '0;
      alloc_done_reg <= 1'b0;
      evict_reg      <= 1'b0;
      evict_tag_reg  <= '0;
      valid_reg      <= '0;
      rr_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            set_reg        <= req_set;
            tag_reg        <= req_tag;
            alloc_req_reg  <= req_alloc;
            // Fresh response fields so irrelevant outputs read as 0
            hit_reg        <= 1'b0;
            way_reg        <= '0;
            alloc_done_reg <= 1'b0;
            evict_reg      <= 1'b0;
            evict_tag_reg  <= '0;
          end
        end
        CMP: begin
          if (any_hit) begin
            hit_reg <= 1'b1;
            way_reg <= hit_way;
          end else if (alloc_req_reg) begin
            way_reg       <= victim_way;
            evict_reg     <= !any_free;
            evict_tag_reg <= any_free ? '0 : tag_read_rsp[victim_way];
          end
        end
        WRITE: begin
          if (tag_write_ready) begin
            valid_reg[set_reg][way_reg] <= 1'b1;
            alloc_done_reg              <= 1'b1;
            // Pointer only advances when a valid line was displaced
            if (evict_reg) rr_reg[set_reg] <= rr_reg[set_reg] + WAY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by state so that anything not in use reads as 0
  assign req_ready        = (state_reg == IDLE);
  assign tag_read_valid   = (state_reg == READ);
  assign tag_read_set     = tag_read_valid ? set_reg : '0;
  assign tag_write_valid  = (state_reg == WRITE);
  assign tag_write_set    = tag_write_valid ? set_reg : '0;
  assign tag_write_way_en = tag_write_valid ? (WAYS'(1) << way_reg) : '0;
  assign tag_write_data   = tag_write_valid ? tag_reg : '0;
  assign rsp_valid        = (state_reg == RESP);
  assign rsp_hit          = rsp_valid && hit_reg;
  assign rsp_way          = rsp_valid ? way_reg : '0;
  assign rsp_alloc        = rsp_valid && alloc_done_reg;
  assign rsp_evict        = rsp_valid && evict_reg;
  assign rsp_evict_tag    = rsp_valid ? evict_tag_reg : '0;

  // The controller never writes a tag already present, so at most one way may match
  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == CMP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Self-checking bench for tag_lookup_ctrl: a behavioural tag array responds
// to the controller's read/write ports, and a cache-level model (valid bits,
// tags, replacement pointers per set) predicts each response and its timing.
module tb_tag_lookup_ctrl;
  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int SET_W = 3;
  localparam int TAG_W = 16;
  localparam int WAY_W = 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic [SET_W-1:0]           req_set = '0;
  logic [TAG_W-1:0]           req_tag = '0;
  logic                       req_alloc = 1'b0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b0;
  logic                       rsp_hit;
  logic [WAY_W-1:0]           rsp_way;
  logic                       rsp_alloc;
  logic                       rsp_evict;
  logic [TAG_W-1:0]           rsp_evict_tag;
  logic                       tag_read_valid;
  logic                       tag_read_ready = 1'b0;
  logic [SET_W-1:0]           tag_read_set;
  logic [WAYS-1:0][TAG_W-1:0] tag_read_rsp;
  logic                       tag_write_valid;
  logic                       tag_write_ready = 1'b0;
  logic [SET_W-1:0]           tag_write_set;
  logic [WAYS-1:0]            tag_write_way_en;
  logic [TAG_W-1:0]           tag_write_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tag_lookup_ctrl #(.WAYS(WAYS), .SETS(SETS), .SET_W(SET_W), .TAG_W(TAG_W), .WAY_W(WAY_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .req_alloc(req_alloc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_alloc(rsp_alloc), .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
    .tag_read_valid(tag_read_valid), .tag_read_ready(tag_read_ready),
    .tag_read_set(tag_read_set), .tag_read_rsp(tag_read_rsp),
    .tag_write_valid(tag_write_valid), .tag_write_ready(tag_write_ready),
    .tag_write_set(tag_write_set), .tag_write_way_en(tag_write_way_en),
    .tag_write_data(tag_write_data)
  );

  // Behavioural tag array: junk on the read bus except the cycle after accept
  logic [TAG_W-1:0] sram [SETS][WAYS];
  logic scramble = 1'b1;
  always @(posedge clk) begin
    if (scramble) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) sram[s][w] <= TAG_W'($urandom);
    end else if (tag_write_valid && tag_write_ready) begin
      for (int w = 0; w < WAYS; w++)
        if (tag_write_way_en[w]) sram[tag_write_set][w] <= tag_write_data;
    end
    for (int w = 0; w < WAYS; w++)
      tag_read_rsp[w] <= (tag_read_valid && tag_read_ready) ? sram[tag_read_set][w] : TAG_W'($urandom);
  end

  // Cache-level reference model
  bit               m_vld [SETS][WAYS];
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  int               m_rr  [SETS];

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
    end
  endtask

  // One lookup with given stall counts on read accept, write accept and response consume
  task automatic do_lookup(input int s, input logic [TAG_W-1:0] t, input bit a,
                           input int rs, input int ws, input int ps, input string name);
    bit e_hit = 1'b0, e_alloc = 1'b0, e_evict = 1'b0, done = 1'b0;
    int e_way = 0, fw = -1, cyc;
    logic [TAG_W-1:0] e_etag = '0;
    logic [WAYS-1:0] e_en;
    int rd_first = -1, rd_cnt = 0, wr_first = -1, wr_cnt = 0, rp_first = -1, rp_cnt = 0;
    int e_wr_first, e_rp_first;
    for (int w = 0; w < WAYS; w++)
      if (!e_hit && m_vld[s][w] && m_tag[s][w] == t) begin e_hit = 1'b1; e_way = w; end
    if (!e_hit && a) begin
      for (int w = 0; w < WAYS; w++) if (fw < 0 && !m_vld[s][w]) fw = w;
      e_alloc = 1'b1;
      if (fw >= 0) e_way = fw;
      else begin
        e_way = m_rr[s]; e_evict = 1'b1; e_etag = m_tag[s][e_way];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_vld[s][e_way] = 1'b1; m_tag[s][e_way] = t;
    end
    e_en = WAYS'(1) << e_way;
    e_wr_first = e_alloc ? 3 + rs : -1;
    e_rp_first = e_alloc ? 4 + rs + ws : 3 + rs;

    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_set = SET_W'(s); req_tag = t; req_alloc = a;
    @(posedge clk); #1;
    req_valid = 1'b0; req_set = SET_W'($urandom); req_tag = TAG_W'($urandom); req_alloc = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 60) begin
      vectors++;
      if (req_ready !== 1'b0 || (tag_read_valid && tag_write_valid)) begin
        miscompares++;
        $display("FAIL %s busy cyc%0d: req_ready=%b rd=%b wr=%b want 0/not both", name, cyc,
                 req_ready, tag_read_valid, tag_write_valid);
      end
      if (tag_read_valid) begin
        if (rd_first < 0) rd_first = cyc;
        rd_cnt++;
        vectors++;
        if (tag_read_set !== SET_W'(s)) begin
          miscompares++; $display("FAIL %s read_set: got %0d want %0d", name, tag_read_set, s);
        end
      end
      vectors++;
      if (tag_write_valid) begin
        if (wr_first < 0) wr_first = cyc;
        wr_cnt++;
        if ({tag_write_set, tag_write_way_en, tag_write_data} !== {SET_W'(s), e_en, t}) begin
          miscompares++;
          $display("FAIL %s write: got set=%0d en=%b data=%h want set=%0d en=%b data=%h", name,
                   tag_write_set, tag_write_way_en, tag_write_data, s, e_en, t);
        end
      end else if ({tag_write_set, tag_write_way_en, tag_write_data} !== '0) begin
        miscompares++; $display("FAIL %s write_idle: got nonzero write fields want 0", name);
      end
      vectors++;
      if (rsp_valid) begin
        if (rp_first < 0) rp_first = cyc;
        rp_cnt++;
        if ({rsp_hit, rsp_way, rsp_alloc, rsp_evict, rsp_evict_tag} !==
            {e_hit, WAY_W'(e_way), e_alloc, e_evict, e_etag}) begin
          miscompares++;
          $display("FAIL %s rsp: got hit=%b way=%0d alloc=%b evict=%b etag=%h want hit=%b way=%0d alloc=%b evict=%b etag=%h",
                   name, rsp_hit, rsp_way, rsp_alloc, rsp_evict, rsp_evict_tag,
                   e_hit, e_way, e_alloc, e_evict, e_etag);
        end
      end else if ({rsp_hit, rsp_way, rsp_alloc, rsp_evict, rsp_evict_tag} !== '0) begin
        miscompares++; $display("FAIL %s rsp_idle: got nonzero rsp fields want 0", name);
      end
      tag_read_ready  = tag_read_valid  ? (rd_cnt > rs) : 1'($urandom);
      tag_write_ready = tag_write_valid ? (wr_cnt > ws) : 1'($urandom);
      rsp_ready       = rsp_valid       ? (rp_cnt > ps) : 1'($urandom);
      if (rsp_valid && rsp_ready) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (!done || rd_first != 1 || rd_cnt != rs + 1 || wr_first != e_wr_first ||
        wr_cnt != (e_alloc ? ws + 1 : 0) || rp_first != e_rp_first || rp_cnt != ps + 1) begin
      miscompares++;
      $display("FAIL %s timing: got done=%0d rd@%0d x%0d wr@%0d x%0d rsp@%0d x%0d want done=1 rd@1 x%0d wr@%0d x%0d rsp@%0d x%0d",
               name, done, rd_first, rd_cnt, wr_first, wr_cnt, rp_first, rp_cnt,
               rs + 1, e_wr_first, e_alloc ? ws + 1 : 0, e_rp_first, ps + 1);
    end
    $display("txn %-8s set=%0d tag=%h alloc_req=%0d stalls=%0d/%0d/%0d -> hit=%0d way=%0d alloc=%0d evict=%0d etag=%h rsp@%0d",
             name, s, t, a, rs, ws, ps, e_hit, e_way, e_alloc, e_evict, e_etag, rp_first);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1 || {rsp_valid, rsp_hit, rsp_way, rsp_alloc, rsp_evict, rsp_evict_tag,
        tag_read_valid, tag_read_set, tag_write_valid, tag_write_set, tag_write_way_en, tag_write_data} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got req_ready=%b or nonzero outputs want 1/all 0", req_ready);
    end
    scramble = 1'b0;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_basic_alloc_hit();
    do_lookup(2, 16'h1234, 1'b1, 0, 0, 0, "alloc");
    do_lookup(2, 16'h1234, 1'b1, 0, 0, 0, "hit");
  endtask

  task automatic test_rr_evict();
    for (int i = 0; i < 4; i++) do_lookup(5, TAG_W'(16'hA + i), 1'b1, 0, 0, 0, "fill");
    do_lookup(5, 16'h000E, 1'b1, 0, 0, 0, "evict");
    do_lookup(5, 16'h000F, 1'b1, 0, 0, 0, "evict");
    for (int i = 0; i < 4; i++) do_lookup(5, TAG_W'(16'h20 + i), 1'b1, 0, 0, 0, "rrwrap");
    do_lookup(5, 16'h000A, 1'b0, 0, 0, 0, "gone");
    do_lookup(5, 16'h0023, 1'b0, 0, 0, 0, "hit");
  endtask

  task automatic test_no_alloc_miss();
    do_lookup(3, 16'hBEEF, 1'b0, 0, 0, 0, "noalloc");
    do_lookup(3, 16'hBEEF, 1'b0, 0, 0, 0, "noalloc");
  endtask

  task automatic test_stalls();
    do_lookup(6, 16'h0606, 1'b1, 3, 2, 4, "stall");
    do_lookup(6, 16'h0606, 1'b1, 3, 0, 4, "stall");
  endtask

  task automatic test_same_tag_sets();
    do_lookup(0, 16'h0055, 1'b1, 0, 0, 0, "set0");
    do_lookup(7, 16'h0055, 1'b1, 0, 0, 0, "set7");
    do_lookup(0, 16'h0055, 1'b0, 0, 0, 0, "set0");
    do_lookup(7, 16'h0055, 1'b0, 0, 0, 0, "set7");
  endtask

  task automatic test_reset_mid_write();
    int waited = 0;
    req_valid = 1'b1; req_set = 3'd4; req_tag = 16'h7777; req_alloc = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; tag_read_ready = 1'b1; tag_write_ready = 1'b0;
    while (!tag_write_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (tag_write_valid !== 1'b1) begin
      miscompares++; $display("FAIL midreset_reach_write: got %b want 1", tag_write_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || {rsp_valid, rsp_hit, rsp_way, rsp_alloc, rsp_evict, rsp_evict_tag,
        tag_read_valid, tag_read_set, tag_write_valid, tag_write_set, tag_write_way_en, tag_write_data} !== '0) begin
      miscompares++; $display("FAIL midreset_outputs: got req_ready=%b wr=%b want 1/all 0", req_ready, tag_write_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    $display("txn midreset asserted during write");
    do_lookup(2, 16'h1234, 1'b0, 0, 0, 0, "postrst");
    do_lookup(4, 16'h7777, 1'b0, 0, 0, 0, "postrst");
    for (int i = 0; i < 5; i++) do_lookup(5, TAG_W'(16'h30 + i), 1'b1, 0, 0, 0, "postrst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      do_lookup($urandom_range(0, SETS - 1), TAG_W'(16'h100 + $urandom_range(0, 9)),
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic_alloc_hit();
    test_rr_evict();
    test_no_alloc_miss();
    test_stalls();
    test_same_tag_sets();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
- Client-side controller for the per-way tag SRAM array: issues tag reads and tag writes over the array's valid/ready ports.
- Accepts one lookup request at a time (set and tag), compares the returned tags of all ways, and reports hit and way.
- On a miss with allocation requested, it picks a victim way, writes the new tag, and reports the eviction.
- Owns per-set/per-way valid bits and per-set round-robin replacement pointers in flops. The array itself stores tags only.

Parameters:
WAYS, 4, number of ways (power of 2, ≥2)
SETS, 8, number of sets (power of 2)
SET_W, $clog2(SETS), set index width
TAG_W, 16, tag width
WAY_W, $clog2(WAYS), way index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  lookup request valid
req_ready  out  1  controller can accept a request
req_set  in  SET_W  lookup set
req_tag  in  TAG_W  lookup tag
req_alloc  in  1  allocate on miss
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_hit  out  1  tag matched a valid way
rsp_way  out  WAY_W  hit way or allocated way
rsp_alloc  out  1  allocation performed
rsp_evict  out  1  allocated way held a valid line
rsp_evict_tag  out  TAG_W  tag of the evicted line
tag_read_valid  out  1  array read request
tag_read_ready  in  1  array read accept
tag_read_set  out  SET_W  array read set
tag_read_rsp  in  WAYS x TAG_W  per-way read data, valid the cycle after read accept
tag_write_valid  out  1  array write request
tag_write_ready  in  1  array write accept
tag_write_set  out  SET_W  array write set
tag_write_way_en  out  WAYS  one-hot way enable
tag_write_data  out  TAG_W  tag written

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low. Reset and every mid-operation assertion of reset produce the same result:
  - FSM goes to IDLE.
  - All valid bits are cleared, all round-robin pointers are set to 0, all captured registers are cleared.
  - Every output is 0, except req_ready, which is 1 in IDLE.
- FSM states: IDLE, READ, CMP, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture set, tag and alloc, then go to READ.
- READ:
  - tag_read_valid=1 and tag_read_set=captured set.
  - Hold the request until tag_read_ready; then go to CMP.
- CMP (exactly one cycle, the cycle after read accept):
  - Sample tag_read_rsp.
  - hit_vec[w] = valid[set][w] && tag_read_rsp[w]==tag.
  - Hit: the way is the lowest-index match (more than one match is an assertion failure). Register rsp_hit=1 and rsp_way, then go to RESP.
  - Miss with alloc=0: rsp_hit=0, rsp_way=0, rsp_alloc=0, go to RESP.
  - Miss with alloc=1, choose a victim:
    - If any way is invalid, take the lowest-index invalid way; rsp_evict=0.
    - Otherwise take rr[set]; rsp_evict=1 and rsp_evict_tag = tag_read_rsp[victim] as sampled in CMP.
    - Go to WRITE.
- WRITE:
  - tag_write_valid=1, tag_write_set=set, tag_write_way_en=one-hot victim, tag_write_data=tag.
  - Hold until tag_write_ready.
  - On accept: set valid[set][victim]=1. If the eviction was of a valid way, rr[set] = rr[set]+1 mod WAYS (wraps). Then go to RESP with rsp_alloc=1 and rsp_way=victim.
- RESP:
  - rsp_valid=1, response fields stable.
  - Hold until rsp_ready; then return to IDLE.
- tag_read_valid and tag_write_valid are never asserted in the same cycle, so the array's write-priority blocking of reads never arises.
- A new request is accepted only in IDLE. There is no overlap and no bypass.
- Latency, counted from the request-accept cycle (cycle 0), with ready signals held high:
  - tag_read_valid in cycle 1.
  - Hit or non-alloc miss: rsp_valid in cycle 3.
  - Alloc miss: tag_write_valid in cycle 3, rsp_valid in cycle 4.
- Outputs not relevant to the current response are held at 0:
  - rsp_evict_tag is 0 unless rsp_evict=1.
  - rsp_way is 0 on a non-alloc miss.

Test Plan:
- After reset: lookup set=2, tag=0x1234, alloc=1 → read in cycle 1; write in cycle 3 with way_en=0001 and data 0x1234; rsp in cycle 4 with hit=0, alloc=1, way=0, evict=0. Repeat the same lookup → rsp hit=1, way=0 in cycle 3, no write.
- Fill set 5 with tags 0xA..0xD (ways 0–3), then alloc tag 0xE → victim way 0, evict=1, evict_tag=0xA. Then alloc 0xF → way 1, evict_tag=0xB. Four more alloc misses → rr wraps back to way 1.
- Miss with alloc=0 on an empty set → hit=0, alloc=0, way=0; tag_write_valid never asserted; valid bits unchanged.
- Hold tag_read_ready=0 for 3 cycles, then tag_write_ready=0 for 2 cycles → requests held stable, rsp_valid delayed by the stall count, req_ready=0 throughout. Hold rsp_ready=0 for 4 cycles → response fields held stable.
- Assert rst_n low during WRITE → immediately all outputs are 0 and req_ready=1. A later lookup of the previously written tag → miss, because valid bits were cleared.
- Same tag 0x55 in sets 0 and 7 → independent allocation, both way 0; each set hits independently.
